ex_wb_reg: RTL and testbench
============================

EX_WB_REG -- requirements
Module: ex_wb_reg

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the datapath width of every data port.
REQ-002 Parameter RA_W, default 6, SHALL set the destination register address width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-005 Port stall, input, 1, SHALL hold all registered state when high.
REQ-006 Port flush, input, 1, SHALL insert a bubble when high.
REQ-007 Port in_valid, input, 1, SHALL mark the EX-side inputs as a real instruction.
REQ-008 Ports alu_res, mem_data, pc_next, imm, reg_b, aux, input, WIDTH each, SHALL be the six writeback candidates, in that order.
REQ-009 Port wb_sel_in, input, 3, SHALL be the writeback-source select: 0 alu_res … 5 aux.
REQ-010 Port reg_write_in, input, 1, SHALL be the register-file write request.
REQ-011 Port rd_in, input, RA_W, SHALL be the destination register.
REQ-012 Ports d1_q..d6_q, output, WIDTH each, SHALL be the registered candidates driving the downstream 6:1 mux.
REQ-013 Port wb_sel_q, output, 3, SHALL be the registered select for the downstream mux.
REQ-014 Port reg_write_q, output, 1, SHALL be the registered, qualified write enable.
REQ-015 Port rd_q, output, RA_W, SHALL be the registered destination.
REQ-016 Port valid_q, output, 1, SHALL flag that the stage holds a real instruction.
REQ-017 Port sel_err, output, 1, SHALL be a sticky illegal-select flag.
REQ-018 Port retired, output, 32, SHALL count instructions leaving the stage.

Function
REQ-019 Capture SHALL occur on each edge with rst_n=1, stall=0 and flush=0; outputs SHALL reflect inputs one cycle later (latency 1).
REQ-020 stall=1 SHALL hold every output and the counter unchanged.
REQ-021 flush=1 SHALL clear valid_q, reg_write_q, wb_sel_q and rd_q to 0, leave d1_q..d6_q unchanged, and win over stall.
REQ-022 reg_write_q SHALL load reg_write_in AND in_valid AND (wb_sel_in<6).
REQ-023 wb_sel_in of 6 or 7 with in_valid=1 on a capture edge SHALL load wb_sel_q=0 and set sel_err to 1 until reset.
REQ-024 With in_valid=0, a capture SHALL behave as a bubble: valid_q=0 and reg_write_q=0, with data still captured.
REQ-025 retired SHALL increment by 1 on each edge with valid_q=1, stall=0 and rst_n=1, including edges where flush=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 wb_sel_q SHALL never present 6 or 7, so the downstream mux always receives a decoded select.

Reset
REQ-027 rst_n=0 at an edge SHALL clear all outputs (d1_q..d6_q, wb_sel_q, rd_q, reg_write_q, valid_q, sel_err, retired) to 0, overriding stall and flush.
REQ-028 Reset asserted mid-stall SHALL produce zero outputs on the next edge, with no held state surviving.

Structure
REQ-029 WIDTH, RA_W and the select encodings (SEL_ALU=0 … SEL_AUX=5) SHALL reside in the shared processor package, reused by the control unit.
REQ-030 The block SHALL be flat except for one sub-module, wb_retire_cnt (the 32-bit retire counter).

Verification
REQ-031 Reset: hold rst_n=0 for 2 cycles with random inputs -> all outputs 0, retired=0.
REQ-032 Capture: alu_res=0x11, mem_data=0x22, wb_sel_in=1, reg_write_in=1, rd_in=5, in_valid=1 -> next cycle d2_q=0x22, wb_sel_q=1, reg_write_q=1, rd_q=5, valid_q=1.
REQ-033 Stall/flush: stall=1 for 3 cycles -> outputs frozen, retired frozen; then stall=1 and flush=1 together -> valid_q=0, reg_write_q=0.
REQ-034 Illegal select: wb_sel_in=7, reg_write_in=1, in_valid=1 -> wb_sel_q=0, reg_write_q=0, sel_err=1, still 1 after 10 legal instructions.
REQ-035 Counter wrap: force retired to 0xFFFFFFFF, retire one valid instruction -> retired=0.
REQ-036 Reset mid-stall: stall=1 with valid_q=1, then rst_n=0 for one edge -> all outputs 0.

Source files
------------

// File: rtl/ex_wb_reg_pkg.sv
// Shared processor definitions: datapath widths and writeback-source select encodings.
// Imported by the EX/WB stage register and the control unit.
package ex_wb_reg_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 6;
  localparam int SEL_W      = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_ALU = 3'd0,
    SEL_MEM = 3'd1,
    SEL_PC  = 3'd2,
    SEL_IMM = 3'd3,
    SEL_REGB = 3'd4,
    SEL_AUX = 3'd5
  } wb_sel_e;

  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return (sel <= SEL_AUX);
  endfunction

endpackage

// File: rtl/wb_retire_cnt.sv
// 32-bit wrapping retire counter; advances one per enabled edge, 1-cycle update latency.
// No backpressure of its own: the caller gates i_en with stall.
module wb_retire_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [31:0] o_cnt
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 32'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ex_wb_reg.sv
// EX/WB pipeline register: six writeback candidates plus control, latency 1 cycle.
// stall holds everything; flush bubbles control (wins over stall); reset overrides both.
module ex_wb_reg
  import ex_wb_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int RA_W  = REG_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [WIDTH-1:0] pc_next,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [WIDTH-1:0] aux,
  input  logic [2:0]       wb_sel_in,
  input  logic             reg_write_in,
  input  logic [RA_W-1:0]  rd_in,
  output logic [WIDTH-1:0] d1_q,
  output logic [WIDTH-1:0] d2_q,
  output logic [WIDTH-1:0] d3_q,
  output logic [WIDTH-1:0] d4_q,
  output logic [WIDTH-1:0] d5_q,
  output logic [WIDTH-1:0] d6_q,
  output logic [2:0]       wb_sel_q,
  output logic             reg_write_q,
  output logic [RA_W-1:0]  rd_q,
  output logic             valid_q,
  output logic             sel_err,
  output logic [31:0]      retired
);

  logic [WIDTH-1:0] r_d1, r_d2, r_d3, r_d4, r_d5, r_d6;
  logic [2:0]       r_sel;
  logic             r_rw;
  logic [RA_W-1:0]  r_rd;
  logic             r_valid;
  logic             r_sel_err;
  logic             w_sel_ok;
  logic             w_cnt_en;

  assign w_sel_ok = sel_legal(wb_sel_in);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_d1      <= '0;
      r_d2      <= '0;
      r_d3      <= '0;
      r_d4      <= '0;
      r_d5      <= '0;
      r_d6      <= '0;
      r_sel     <= SEL_ALU;
      r_rw      <= 1'b0;
      r_rd      <= '0;
      r_valid   <= 1'b0;
      r_sel_err <= 1'b0;
    end else if (flush) begin
      // Candidates are left as-is; only the control that could commit is cleared.
      r_sel   <= SEL_ALU;
      r_rw    <= 1'b0;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_d1    <= alu_res;
      r_d2    <= mem_data;
      r_d3    <= pc_next;
      r_d4    <= imm;
      r_d5    <= reg_b;
      r_d6    <= aux;
      r_sel   <= w_sel_ok ? wb_sel_in : SEL_ALU;
      r_rw    <= reg_write_in & in_valid & w_sel_ok;
      r_rd    <= rd_in;
      r_valid <= in_valid;
      if (in_valid && !w_sel_ok) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  // An instruction leaves the stage whenever the stage advances while holding it.
  assign w_cnt_en = r_valid & ~stall;

  wb_retire_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_cnt_en),
    .o_cnt (retired)
  );

  assign d1_q        = r_d1;
  assign d2_q        = r_d2;
  assign d3_q        = r_d3;
  assign d4_q        = r_d4;
  assign d5_q        = r_d5;
  assign d6_q        = r_d6;
  assign wb_sel_q    = r_sel;
  assign reg_write_q = r_rw;
  assign rd_q        = r_rd;
  assign valid_q     = r_valid;
  assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_ex_wb_reg.sv
// Directed bench for ex_wb_reg: reset, capture, stall/flush, illegal select, wrap, reset mid-stall.
module tb_ex_wb_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid, reg_write_in;
  logic [31:0] alu_res, mem_data, pc_next, imm, reg_b, aux;
  logic [2:0]  wb_sel_in;
  logic [5:0]  rd_in;
  logic [31:0] d1_q, d2_q, d3_q, d4_q, d5_q, d6_q, retired;
  logic [2:0]  wb_sel_q;
  logic        reg_write_q, valid_q, sel_err;
  logic [5:0]  rd_q;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_wb_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_res(alu_res), .mem_data(mem_data), .pc_next(pc_next), .imm(imm),
    .reg_b(reg_b), .aux(aux), .wb_sel_in(wb_sel_in), .reg_write_in(reg_write_in),
    .rd_in(rd_in), .d1_q(d1_q), .d2_q(d2_q), .d3_q(d3_q), .d4_q(d4_q),
    .d5_q(d5_q), .d6_q(d6_q), .wb_sel_q(wb_sel_q), .reg_write_q(reg_write_q),
    .rd_q(rd_q), .valid_q(valid_q), .sel_err(sel_err), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge pass, sample on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic rw,
                       input logic [5:0] rd, input logic [31:0] base);
    in_valid = v; wb_sel_in = sel; reg_write_in = rw; rd_in = rd;
    alu_res = base + 32'h1; mem_data = base + 32'h2; pc_next = base + 32'h3;
    imm = base + 32'h4; reg_b = base + 32'h5; aux = base + 32'h6;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".d1"}, d1_q, 0);
    check({tag, ".d2"}, d2_q, 0);
    check({tag, ".d3"}, d3_q, 0);
    check({tag, ".d4"}, d4_q, 0);
    check({tag, ".d5"}, d5_q, 0);
    check({tag, ".d6"}, d6_q, 0);
    check({tag, ".sel"}, {29'd0, wb_sel_q}, 0);
    check({tag, ".rd"}, {26'd0, rd_q}, 0);
    check({tag, ".rw"}, {31'd0, reg_write_q}, 0);
    check({tag, ".valid"}, {31'd0, valid_q}, 0);
    check({tag, ".sel_err"}, {31'd0, sel_err}, 0);
    check({tag, ".retired"}, retired, 0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 6'd0, 32'h0);
    @(negedge clk);

    // Reset held for two edges under random inputs, including stall/flush.
    for (int i = 0; i < 2; i++) begin
      stall = 1'($urandom); flush = 1'($urandom);
      drive(1'($urandom), 3'($urandom), 1'($urandom), 6'($urandom), $urandom);
      step();
    end
    check_all_zero("reset");

    // Plain capture.
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 3'd1, 1'b1, 6'd5, 32'h10);
    alu_res = 32'h11; mem_data = 32'h22;
    step();
    check("cap.d1", d1_q, 32'h11);
    check("cap.d2", d2_q, 32'h22);
    check("cap.d3", d3_q, 32'h13);
    check("cap.d6", d6_q, 32'h16);
    check("cap.sel", {29'd0, wb_sel_q}, 1);
    check("cap.rw", {31'd0, reg_write_q}, 1);
    check("cap.rd", {26'd0, rd_q}, 5);
    check("cap.valid", {31'd0, valid_q}, 1);
    check("cap.retired", retired, 0);

    // Stall three cycles with different inputs: everything frozen.
    stall = 1'b1;
    drive(1'b0, 3'd4, 1'b0, 6'd9, 32'h900);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.d2", d2_q, 32'h22);
      check("stall.valid", {31'd0, valid_q}, 1);
      check("stall.rd", {26'd0, rd_q}, 5);
      check("stall.retired", retired, 0);
    end

    // Flush wins over stall: control cleared, data held, counter held by stall.
    flush = 1'b1;
    step();
    check("sflush.valid", {31'd0, valid_q}, 0);
    check("sflush.rw", {31'd0, reg_write_q}, 0);
    check("sflush.sel", {29'd0, wb_sel_q}, 0);
    check("sflush.rd", {26'd0, rd_q}, 0);
    check("sflush.d2", d2_q, 32'h22);
    check("sflush.retired", retired, 0);

    // Capture, then a flush without stall still retires the held instruction.
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 3'd0, 1'b1, 6'd3, 32'hA0);
    step();
    check("cap2.d1", d1_q, 32'hA1);
    check("cap2.retired", retired, 0);
    flush = 1'b1;
    drive(1'b1, 3'd2, 1'b1, 6'd7, 32'hF0);
    step();
    check("flush.valid", {31'd0, valid_q}, 0);
    check("flush.d1", d1_q, 32'hA1);
    check("flush.retired", retired, 1);

    // Illegal select.
    flush = 1'b0;
    drive(1'b1, 3'd7, 1'b1, 6'd4, 32'h300);
    step();
    check("ill.sel", {29'd0, wb_sel_q}, 0);
    check("ill.rw", {31'd0, reg_write_q}, 0);
    check("ill.valid", {31'd0, valid_q}, 1);
    check("ill.sel_err", {31'd0, sel_err}, 1);
    check("ill.retired", retired, 1);

    // Ten legal instructions; sel_err stays set, each edge retires one.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'(i % 6), 1'b1, 6'(i), 32'h1000 + 32'(i * 16));
      step();
    end
    check("legal.sel_err", {31'd0, sel_err}, 1);
    check("legal.sel", {29'd0, wb_sel_q}, 3);
    check("legal.rw", {31'd0, reg_write_q}, 1);
    check("legal.rd", {26'd0, rd_q}, 9);
    check("legal.retired", retired, 11);

    // Bubble: data captured, valid and write enable dropped.
    drive(1'b0, 3'd2, 1'b1, 6'd8, 32'h770);
    step();
    check("bub.d1", d1_q, 32'h771);
    check("bub.sel", {29'd0, wb_sel_q}, 2);
    check("bub.valid", {31'd0, valid_q}, 0);
    check("bub.rw", {31'd0, reg_write_q}, 0);
    check("bub.retired", retired, 12);

    // Counter wrap.
    drive(1'b1, 3'd5, 1'b1, 6'd2, 32'h500);
    step();
    check("pre_wrap.valid", {31'd0, valid_q}, 1);
    force dut.u_cnt.r_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.u_cnt.r_cnt;
    step();
    check("wrap.retired", retired, 0);
    check("wrap.valid", {31'd0, valid_q}, 1);

    // Reset during a stall with a live instruction.
    stall = 1'b1;
    step();
    check("rstall.valid", {31'd0, valid_q}, 1);
    check("rstall.retired", retired, 0);
    rst_n = 1'b0;
    step();
    check_all_zero("rst_mid_stall");

    rst_n = 1'b1; stall = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, expected completion before 20000");
    $fatal(1);
  end

endmodule
